console_dl11: RTL and testbench

//  DL11 console serial line on the IO page: RCSR 177560, RBUF 177562, XCSR 177564, XBUF 177566.

---
 rtl/console_dl11_pkg.sv | 39 +++
 rtl/dl11_uart.sv | 171 +++++++++++++++++
 rtl/console_dl11.sv | 135 +++++++++++++
 tb/tb_console_dl11.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_dl11_pkg.sv
// Shared definitions for the DL11 console line: IO page offsets, CSR bit positions
// and the state encoding used by both serial state machines.
package console_dl11_pkg;

   localparam logic [12:0] ADDR_RCSR = 13'o17560;
   localparam logic [12:0] ADDR_RBUF = 13'o17562;
   localparam logic [12:0] ADDR_XCSR = 13'o17564;
   localparam logic [12:0] ADDR_XBUF = 13'o17566;

   localparam int BIT_DONE  = 7;
   localparam int BIT_IE    = 6;
   localparam int BIT_MAINT = 2;
   localparam int BIT_ERR   = 15;
   localparam int BIT_OR    = 14;
   localparam int BIT_FE    = 13;

   // Word index within the 4-register block (iopage_addr[2:1])
   localparam logic [1:0] SEL_RCSR = 2'd0;
   localparam logic [1:0] SEL_RBUF = 2'd1;
   localparam logic [1:0] SEL_XCSR = 2'd2;
   localparam logic [1:0] SEL_XBUF = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // Byte reads return the addressed byte right-justified.
   function automatic logic [15:0] bus_lane(input logic [15:0] word,
                                            input logic byte_op,
                                            input logic hi);
      if (!byte_op)
         return word;
      return hi ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
   endfunction

endpackage

// File: rtl/dl11_uart.sv
// 8N1 transmitter and receiver for the DL11 console, one bit every CLK_DIV clocks.
// The receiver samples at mid-bit after a 2-flop synchronizer.
import console_dl11_pkg::*;

module dl11_uart #(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_line,
   input  logic       rx_in,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_stop
);

   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

   uart_state_t r_tx_state;
   logic [15:0] r_tx_cnt;
   logic [2:0]  r_tx_bit;
   logic [7:0]  r_tx_shift;
   logic        r_tx_line;
   logic        r_tx_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_state <= ST_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_line  <= 1'b1;
         r_tx_ready <= 1'b1;
      end else begin
         case (r_tx_state)
            ST_IDLE: begin
               if (tx_start) begin
                  r_tx_shift <= tx_data;
                  r_tx_ready <= 1'b0;
                  r_tx_line  <= 1'b0;
                  r_tx_cnt   <= '0;
                  r_tx_state <= ST_START;
               end
            end
            ST_START: begin
               if (r_tx_cnt == DIV_LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_bit   <= '0;
                  r_tx_line  <= r_tx_shift[0];
                  r_tx_state <= ST_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (r_tx_cnt == DIV_LAST) begin
                  r_tx_cnt <= '0;
                  if (r_tx_bit == 3'd7) begin
                     r_tx_line  <= 1'b1;
                     r_tx_state <= ST_STOP;
                  end else begin
                     r_tx_bit   <= r_tx_bit + 3'd1;
                     r_tx_line  <= r_tx_shift[1];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (r_tx_cnt == DIV_LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_ready <= 1'b1;
                  r_tx_state <= ST_IDLE;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            default: r_tx_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_ready = r_tx_ready;
   assign tx_line  = r_tx_line;

   uart_state_t r_rx_state;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_shift;
   logic        r_rx_sync1;
   logic        r_rx_sync2;
   logic        r_rx_prev;
   logic        r_rx_valid;
   logic [7:0]  r_rx_data;
   logic        r_rx_stop;
   logic        w_rx_fall;

   assign w_rx_fall = r_rx_prev & ~r_rx_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_state <= ST_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_rx_stop  <= 1'b1;
      end else begin
         r_rx_sync1 <= rx_in;
         r_rx_sync2 <= r_rx_sync1;
         r_rx_prev  <= r_rx_sync2;
         r_rx_valid <= 1'b0;
         case (r_rx_state)
            ST_IDLE: begin
               if (w_rx_fall) begin
                  r_rx_cnt   <= '0;
                  r_rx_state <= ST_START;
               end
            end
            ST_START: begin
               // Mid start bit: a high line here was only a glitch
               if (r_rx_cnt == HALF_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_bit   <= '0;
                  r_rx_state <= r_rx_sync2 ? ST_IDLE : ST_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (r_rx_cnt == DIV_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                  if (r_rx_bit == 3'd7)
                     r_rx_state <= ST_STOP;
                  else
                     r_rx_bit <= r_rx_bit + 3'd1;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (r_rx_cnt == DIV_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_valid <= 1'b1;
                  r_rx_data  <= r_rx_shift;
                  r_rx_stop  <= r_rx_sync2;
                  r_rx_state <= ST_IDLE;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            default: r_rx_state <= ST_IDLE;
         endcase
      end
   end

   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign rx_stop  = r_rx_stop;

endmodule

// File: rtl/console_dl11.sv
// DL11 console line on the IO page (RCSR/RBUF/XCSR/XBUF at 17560..17566): bus decode and CSRs.
// Define DL11_MAINT_EN to implement the XCSR MAINT loopback bit.
import console_dl11_pkg::*;

module console_dl11 #(
   parameter int CLK_DIV = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:0] iopage_addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        decode,
   input  logic        iopage_rd,
   input  logic        iopage_wr,
   input  logic        iopage_byte_op,
   input  logic        rxd,
   output logic        txd,
   output logic        rx_int,
   output logic        tx_int
);

   logic [1:0]  w_sel;
   logic        w_wr_lo;
   logic        w_rbuf_rd;
   logic        w_tx_start;
   logic        w_tx_ready;
   logic        w_tx_line;
   logic        w_rx_in;
   logic        w_rx_valid;
   logic [7:0]  w_rx_data;
   logic        w_rx_stop;
   logic        w_maint;
   logic [15:0] w_reg;
   logic        w_unused;

   logic        r_rx_done;
   logic        r_rx_ie;
   logic        r_or;
   logic        r_fe;
   logic [7:0]  r_rbuf;
   logic        r_tx_ie;
   logic        r_rx_int;
   logic        r_tx_int;

   assign decode = (iopage_addr[12:3] == ADDR_RCSR[12:3]);
   assign w_sel  = iopage_addr[2:1];

   // All writable bits live in the low byte; odd-address byte writes touch nothing.
   assign w_wr_lo    = iopage_wr & decode & (~iopage_byte_op | ~iopage_addr[0]);
   assign w_rbuf_rd  = iopage_rd & decode & (w_sel == SEL_RBUF);
   assign w_tx_start = w_wr_lo & (w_sel == SEL_XBUF);

   always_comb begin
      w_reg = '0;
      case (w_sel)
         SEL_RCSR: w_reg = {8'h00, r_rx_done, r_rx_ie, 6'b0};
         SEL_RBUF: w_reg = {r_or | r_fe, r_or, r_fe, 5'b0, r_rbuf};
         SEL_XCSR: w_reg = {8'h00, w_tx_ready, r_tx_ie, 3'b0, w_maint, 2'b0};
         default:  w_reg = '0;
      endcase
   end

   assign data_out = (iopage_rd & decode) ? bus_lane(w_reg, iopage_byte_op, iopage_addr[0])
                                          : 16'h0000;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_done <= 1'b0;
         r_rx_ie   <= 1'b0;
         r_or      <= 1'b0;
         r_fe      <= 1'b0;
         r_rbuf    <= '0;
         r_tx_ie   <= 1'b0;
         r_rx_int  <= 1'b0;
         r_tx_int  <= 1'b0;
      end else begin
         if (w_wr_lo && w_sel == SEL_RCSR)
            r_rx_ie <= data_in[BIT_IE];
         if (w_wr_lo && w_sel == SEL_XCSR)
            r_tx_ie <= data_in[BIT_IE];
         // A character landing on the same edge as an RBUF read is not an overrun
         if (w_rx_valid) begin
            r_rbuf    <= w_rx_data;
            r_rx_done <= 1'b1;
            r_fe      <= ~w_rx_stop;
            r_or      <= r_rx_done & ~w_rbuf_rd;
         end else if (w_rbuf_rd) begin
            r_rx_done <= 1'b0;
            r_or      <= 1'b0;
            r_fe      <= 1'b0;
         end
         r_rx_int <= r_rx_ie & r_rx_done;
         r_tx_int <= r_tx_ie & w_tx_ready;
      end
   end

`ifdef DL11_MAINT_EN
   logic r_maint;

   always_ff @(posedge clk) begin
      if (reset)
         r_maint <= 1'b0;
      else if (w_wr_lo && w_sel == SEL_XCSR)
         r_maint <= data_in[BIT_MAINT];
   end

   assign w_maint = r_maint;
`else
   assign w_maint = 1'b0;
`endif

   // Loopback: receiver listens to the internal tx line while the pin idles high
   assign w_rx_in = w_maint ? w_tx_line : rxd;
   assign txd     = w_tx_line | w_maint;
   assign rx_int  = r_rx_int;
   assign tx_int  = r_tx_int;
   assign w_unused = ^data_in;

   dl11_uart #(
      .CLK_DIV (CLK_DIV)
   ) u_uart (
      .clk      (clk),
      .reset    (reset),
      .tx_start (w_tx_start),
      .tx_data  (data_in[7:0]),
      .tx_ready (w_tx_ready),
      .tx_line  (w_tx_line),
      .rx_in    (w_rx_in),
      .rx_valid (w_rx_valid),
      .rx_data  (w_rx_data),
      .rx_stop  (w_rx_stop)
   );

endmodule

// File: tb/tb_console_dl11.sv
// Randomized self-checking bench for console_dl11 with CLK_DIV=16; a register-level
// model of the DL11 (flags, buffer, frame bit list) supplies every expected value.
module tb_console_dl11;

   localparam int DIV = 16;
   localparam logic [12:0] A_RCSR = 13'o17560;
   localparam logic [12:0] A_RBUF = 13'o17562;
   localparam logic [12:0] A_XCSR = 13'o17564;
   localparam logic [12:0] A_XBUF = 13'o17566;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [12:0] iopage_addr = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        decode;
   logic        iopage_rd = 1'b0;
   logic        iopage_wr = 1'b0;
   logic        iopage_byte_op = 1'b0;
   logic        rxd = 1'b1;
   logic        txd;
   logic        rx_int;
   logic        tx_int;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic       m_done, m_or, m_fe, m_rx_ie, m_tx_ie;
   logic [7:0] m_data;

   always #5 clk = ~clk;

   console_dl11 #(.CLK_DIV(DIV)) dut (
      .clk            (clk),
      .reset          (reset),
      .iopage_addr    (iopage_addr),
      .data_in        (data_in),
      .data_out       (data_out),
      .decode         (decode),
      .iopage_rd      (iopage_rd),
      .iopage_wr      (iopage_wr),
      .iopage_byte_op (iopage_byte_op),
      .rxd            (rxd),
      .txd            (txd),
      .rx_int         (rx_int),
      .tx_int         (tx_int)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %06o expected %06o", tag, got, exp);
      end else begin
         $display("ok   %s: %06o", tag, got);
      end
   endtask

   function automatic logic [15:0] exp_rbuf();
      return {m_or | m_fe, m_or, m_fe, 5'b0, m_data};
   endfunction

   function automatic logic [15:0] exp_rcsr();
      return {8'h00, m_done, m_rx_ie, 6'b0};
   endfunction

   // all bus tasks start and end at a falling edge
   task automatic bus_read(input logic [12:0] a, input logic bo, output logic [15:0] v);
      iopage_addr = a;
      iopage_byte_op = bo;
      iopage_rd = 1'b1;
      #1 v = data_out;
      @(negedge clk);
      iopage_rd = 1'b0;
      iopage_byte_op = 1'b0;
   endtask

   task automatic bus_write(input logic [12:0] a, input logic bo, input logic [15:0] d);
      iopage_addr = a;
      iopage_byte_op = bo;
      data_in = d;
      iopage_wr = 1'b1;
      @(negedge clk);
      iopage_wr = 1'b0;
      iopage_byte_op = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [12:0] a, input logic [15:0] exp);
      logic [15:0] v;
      bus_read(a, 1'b0, v);
      check(tag, v, exp);
   endtask

   task automatic read_rbuf_check(input string tag);
      read_check(tag, A_RBUF, exp_rbuf());
      m_done = 1'b0;
      m_or = 1'b0;
      m_fe = 1'b0;
   endtask

   // Serial character into rxd; model takes it as complete once the stop bit is sent.
   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rxd = frame[k];
         repeat (DIV) @(negedge clk);
      end
      rxd = 1'b1;
      m_or = m_done;
      m_done = 1'b1;
      m_fe = ~stop;
      m_data = b;
      repeat (2) @(negedge clk);
   endtask

   // Write XBUF and follow the whole frame bit by bit at mid-bit.
   task automatic tx_frame(input logic [7:0] b, input logic mid_write);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      bus_write(A_XBUF, 1'b0, {8'h00, b});
      for (int i = 0; i < 10 * DIV; i++) begin
         iopage_wr = 1'b0;
         iopage_rd = 1'b0;
         if (i == 0) begin
            iopage_addr = A_XCSR;
            iopage_rd = 1'b1;
            #1 check("tx_ready_low", data_out, {8'h00, 1'b0, m_tx_ie, 6'b0});
         end
         if (i == 3 * DIV && mid_write) begin
            iopage_addr = A_XBUF;
            data_in = {8'h00, ~b};
            iopage_wr = 1'b1;
         end
         if (i % DIV == DIV / 2)
            check($sformatf("txd_bit%0d", i / DIV), {15'b0, txd}, {15'b0, frame[i / DIV]});
         @(negedge clk);
      end
      iopage_wr = 1'b0;
      iopage_rd = 1'b0;
      read_check("tx_ready_after", A_XCSR, {8'h00, 1'b1, m_tx_ie, 6'b0});
      repeat (2 * DIV) @(negedge clk);
      check("txd_idle_after", {15'b0, txd}, 16'h0001);
   endtask

   logic [15:0] v;
   logic [7:0]  c1, c2;
   logic        tx_seen_low;

   initial begin
      m_done = 0; m_or = 0; m_fe = 0; m_rx_ie = 0; m_tx_ie = 0; m_data = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state and decode
      read_check("rst_xcsr", A_XCSR, 16'o000200);
      read_check("rst_rcsr", A_RCSR, 16'o000000);
      read_check("rst_rbuf", A_RBUF, 16'o000000);
      read_check("rst_xbuf_rd", A_XBUF, 16'o000000);
      check("rst_txd", {15'b0, txd}, 16'h0001);
      check("rst_ints", {14'b0, rx_int, tx_int}, 16'h0000);
      bus_read(A_XCSR, 1'b1, v);
      check("xcsr_byte_lo", v, 16'o000200);
      bus_read(A_XCSR | 13'd1, 1'b1, v);
      check("xcsr_byte_hi", v, 16'o000000);
      iopage_addr = 13'o17570;
      #1 check("decode_out", {15'b0, decode}, 16'h0000);
      bus_read(13'o17570, 1'b0, v);
      check("rd_outside", v, 16'h0000);
      iopage_addr = A_XBUF | 13'd1;
      #1 check("decode_in", {15'b0, decode}, 16'h0001);
      check("no_rd_zero", data_out, 16'h0000);

      // transmit: fixed 0101 with a dropped mid-frame write, then random bytes
      tx_frame(8'o101, 1'b1);
      for (int t = 0; t < 3; t++)
         tx_frame(8'($urandom_range(0, 255)), t[0]);

      // receive: 0x48 then random characters, each read back
      send_rx(8'h48, 1'b1);
      read_check("rx_done", A_RCSR, exp_rcsr());
      read_rbuf_check("rx_0110");
      read_check("rx_done_clr", A_RCSR, exp_rcsr());
      for (int t = 0; t < 4; t++) begin
         send_rx(8'($urandom_range(0, 255)), 1'b1);
         read_rbuf_check($sformatf("rx_rand%0d", t));
      end

      // overrun then framing error
      c1 = 8'($urandom_range(0, 255));
      c2 = 8'($urandom_range(0, 255));
      send_rx(c1, 1'b1);
      send_rx(c2, 1'b1);
      read_rbuf_check("rx_overrun");
      send_rx(c1, 1'b0);
      read_check("rx_fe_done", A_RCSR, exp_rcsr());
      read_rbuf_check("rx_framing");

      // odd-address byte write reaches no writable bit
      bus_write(A_RCSR | 13'd1, 1'b1, 16'hffff);
      read_check("rcsr_odd_wr", A_RCSR, exp_rcsr());

      // receive interrupt
      bus_write(A_RCSR, 1'b0, 16'o000100);
      m_rx_ie = 1'b1;
      check("rx_int_idle", {15'b0, rx_int}, 16'h0000);
      send_rx(8'($urandom_range(0, 255)), 1'b1);
      check("rx_int_set", {15'b0, rx_int}, 16'h0001);
      read_rbuf_check("rx_int_rbuf");
      @(negedge clk);
      check("rx_int_clr", {15'b0, rx_int}, 16'h0000);
      bus_write(A_RCSR, 1'b0, 16'o000000);
      m_rx_ie = 1'b0;

      // transmit interrupt: registered, one clock behind IE
      bus_write(A_XCSR, 1'b0, 16'o000100);
      m_tx_ie = 1'b1;
      check("tx_int_lat", {15'b0, tx_int}, 16'h0000);
      @(negedge clk);
      check("tx_int_set", {15'b0, tx_int}, 16'h0001);
      read_check("xcsr_ie", A_XCSR, 16'o000300);
      bus_write(A_XCSR, 1'b0, 16'o000000);
      m_tx_ie = 1'b0;
      @(negedge clk);
      check("tx_int_clr", {15'b0, tx_int}, 16'h0000);

`ifdef DL11_MAINT_EN
      bus_write(A_XCSR, 1'b0, 16'o000004);
      read_check("maint_set", A_XCSR, 16'o000204);
      bus_write(A_XBUF, 1'b0, 16'o000123);
      tx_seen_low = 1'b0;
      for (int i = 0; i < 11 * DIV; i++) begin
         if (txd !== 1'b1) tx_seen_low = 1'b1;
         @(negedge clk);
      end
      check("maint_txd_quiet", {15'b0, tx_seen_low}, 16'h0000);
      m_or = m_done; m_done = 1'b1; m_fe = 1'b0; m_data = 8'o123;
      read_check("maint_done", A_RCSR, exp_rcsr());
      read_rbuf_check("maint_rbuf");
      bus_write(A_XCSR, 1'b0, 16'o000000);
`endif

      // reset in the middle of a TX frame and an RX frame
      bus_write(A_XBUF, 1'b1, 16'h00a5);
      read_check("byte_xbuf_busy", A_XCSR, 16'o000000);
      rxd = 1'b0;
      repeat (3 * DIV) @(negedge clk);
      reset = 1'b1;
      rxd = 1'b1;
      @(negedge clk);
      check("midrst_txd", {15'b0, txd}, 16'h0001);
      read_check("midrst_xcsr", A_XCSR, 16'o000200);
      reset = 1'b0;
      m_done = 0; m_or = 0; m_fe = 0; m_rx_ie = 0; m_tx_ie = 0; m_data = 0;
      tx_seen_low = 1'b0;
      for (int i = 0; i < 12 * DIV; i++) begin
         if (txd !== 1'b1) tx_seen_low = 1'b1;
         @(negedge clk);
      end
      check("postrst_txd", {15'b0, tx_seen_low}, 16'h0000);
      read_check("postrst_rcsr", A_RCSR, 16'o000000);
      read_check("postrst_rbuf", A_RBUF, 16'o000000);
      read_check("postrst_xcsr", A_XCSR, 16'o000200);
      check("postrst_ints", {14'b0, rx_int, tx_int}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
